// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the five-stage MIPS core.
// Decides the F/D hold, the E bubble and the exception flush each cycle,
// sequences the multi-cycle multiply/divide unit and counts stalled cycles.
// The hold/bubble/flush/PC-select outputs are combinational so a hazard
// takes effect in the same cycle it is detected.

module pipe_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  e_a3,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        d_md,
    input  logic        e_start_mul,
    input  logic        e_start_div,
    input  logic        d_eret,
    input  logic        epc_wr_pending,
    input  logic        req,
    output logic        pc_we,
    output logic        d_we,
    output logic        e_clr,
    output logic        flush,
    output logic [1:0]  pc_sel,
    output logic        md_busy,
    output logic        md_go,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    localparam logic [1:0] PC_SEQ     = 2'd0;
    localparam logic [1:0] PC_HANDLER = 2'd1;
    localparam logic [1:0] PC_EPC     = 2'd2;

    md_state_t  md_state;
    logic [3:0] md_cnt;

    logic rs_stall;
    logic rt_stall;
    logic data_stall;
    logic md_stall;
    logic eret_stall;
    logic stall;
    logic md_start;

    // Operand hazards: a nonzero source that matches a producer in E or M whose
    // result arrives later than D needs it. A tuse of 3 can never lose against
    // a 2-bit tnew, so unused operands never stall.
    always_comb begin
        rs_stall = (d_rs != 5'd0) &&
                   (((d_rs == e_a3) && (e_tnew > d_tuse_rs)) ||
                    ((d_rs == m_a3) && (m_tnew > d_tuse_rs)));
        rt_stall = (d_rt != 5'd0) &&
                   (((d_rt == e_a3) && (e_tnew > d_tuse_rt)) ||
                    ((d_rt == m_a3) && (m_tnew > d_tuse_rt)));
        data_stall = rs_stall || rt_stall;
    end

    // Structural and ordering hazards: MDU users wait for the unit to be free
    // (including the cycle a new operation is starting in E), and eret waits
    // until any in-flight EPC write has landed.
    always_comb begin
        md_start   = e_start_mul || e_start_div;
        md_stall   = d_md && (md_busy || md_start);
        eret_stall = d_eret && epc_wr_pending;
        stall      = data_stall || md_stall || eret_stall;
    end

    // Pipeline register controls. Reset holds everything flushed; an exception
    // request overrides any hazard and redirects to the handler.
    always_comb begin
        pc_we  = 1'b0;
        d_we   = 1'b0;
        e_clr  = 1'b1;
        flush  = 1'b1;
        pc_sel = PC_SEQ;
        md_go  = 1'b0;
        if (reset) begin
            if (req) begin
                pc_we  = 1'b1;
                d_we   = 1'b1;
                e_clr  = 1'b1;
                flush  = 1'b1;
                pc_sel = PC_HANDLER;
                md_go  = 1'b0;
            end else begin
                pc_we  = ~stall;
                d_we   = ~stall;
                e_clr  = stall;
                flush  = 1'b0;
                pc_sel = (d_eret && !stall) ? PC_EPC : PC_SEQ;
                md_go  = md_start;
            end
        end
    end

    // MDU busy sequencer: an accepted start loads the countdown (div wins over
    // mult), busy then lasts exactly that many cycles. An exception does not
    // abort a running operation because its instruction has already committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= 4'd0;
            md_busy  <= 1'b0;
        end else if (md_go) begin
            md_state <= MD_BUSY;
            md_busy  <= 1'b1;
            md_cnt   <= e_start_div ? DIV_LOAD : MULT_LOAD;
        end else begin
            case (md_state)
                MD_BUSY: begin
                    if (md_cnt == 4'd1) begin
                        md_state <= MD_IDLE;
                        md_busy  <= 1'b0;
                        md_cnt   <= 4'd0;
                    end else begin
                        md_cnt <= md_cnt - 4'd1;
                    end
                end
                default: begin
                    md_state <= MD_IDLE;
                    md_busy  <= 1'b0;
                    md_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Performance counter of cycles lost to hazards; cycles taken by an
    // exception redirect are not counted as stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && !req) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. Decides each cycle whether the F/D boundary holds, whether a bubble goes into E, and whether the whole pipeline flushes to the exception handler. It also owns the multi-cycle multiply/divide busy sequencer and a stall-cycle counter. It drives the write-enable, clear and PC-select inputs of the PC, D_REG-class and E-stage pipeline registers.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu (1..15)
- DIV_CYCLES, 10, busy duration of div/divu (1..15)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- d_rs, d_rt  in  5 each  source registers of instruction in D
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until D needs operand; 3 = operand unused
- e_a3, m_a3  in  5 each  destination register in E / M (0 = none)
- e_tnew, m_tnew  in  2 each  cycles until E / M result is available
- d_md  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- e_start_mul, e_start_div  in  1 each  mult-class / div-class instruction in E this cycle
- d_eret  in  1  eret in D
- epc_wr_pending  in  1  mtc0 to EPC currently in E or M
- req  in  1  exception/interrupt request from CP0 (M stage)
- pc_we  out  1  PC enable
- d_we  out  1  F/D register WE
- e_clr  out  1  insert bubble into E
- flush  out  1  flush F/D, D/E, E/M (drives Interrupt of stage registers)
- pc_sel  out  2  0 = sequential/branch, 1 = handler 0x0000_4180, 2 = EPC
- md_busy  out  1  MDU busy, to MDU and hazard logic
- md_go  out  1  accepted MDU start (start gated by ~req)
- stall_cnt  out  32  total stalled cycles since reset

## Operation
- Data stall, rs: d_rs!=0 && ((d_rs==e_a3 && e_tnew>d_tuse_rs) || (d_rs==m_a3 && m_tnew>d_tuse_rs)). The rt term is identical with d_rt/d_tuse_rt. d_tuse=3 never stalls.
- MDU stall: d_md && (md_busy || e_start_mul || e_start_div).
- eret stall: d_eret && epc_wr_pending.
- stall = data | MDU | eret stall.
- Normal, req=0:
  - pc_we = d_we = ~stall; e_clr = stall; flush = 0.
  - pc_sel = 2 when d_eret && ~stall, else 0.
- req=1 overrides everything: flush=1, pc_we=1, d_we=1, e_clr=1, pc_sel=1, stall forced 0.
- MDU sequencer, FSM IDLE/BUSY with 4-bit counter cnt:
  - md_go = (e_start_mul|e_start_div) & ~req.
  - IDLE + md_go → BUSY; cnt loads DIV_CYCLES if e_start_div, else MULT_CYCLES. div wins if both are set.
  - BUSY: cnt decrements each cycle. At cnt==1 → IDLE, cnt=0.
  - md_go in BUSY (illegal; prevented by stall) reloads cnt and stays BUSY.
  - md_busy = (state==BUSY).
  - req does not abort a BUSY sequence, because the older instruction has committed.
- stall_cnt increments on every cycle with stall=1 and req=0; wraps modulo 2^32.

## Timing
- Reset asserted (reset=0), immediately and asynchronously:
  - state=IDLE, cnt=0, stall_cnt=0, md_busy=0.
  - Combinational outputs are forced: pc_we=0, d_we=0, e_clr=1, flush=1, pc_sel=0, md_go=0.
- Reset released: outputs follow the rules above from the same cycle. First edge with reset=1 is the first normal update.
- Stall/flush/pc_sel are combinational from current inputs and registered state, with zero latency.
- md_busy rises the edge after md_go and stays high exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- A D-stage MDU instruction is held for the md_go cycle plus N busy cycles. It advances on the first cycle with md_busy=0.
- Reset asserted mid-BUSY aborts the sequence; no residual busy after release.

## Test plan
- Load-use: e_a3=8, e_tnew=2, d_rs=8, d_tuse_rs=1 → stall: pc_we=0, d_we=0, e_clr=1, stall_cnt +1. Repeat with d_rs=0 → no stall.
- mult: e_start_mul=1 at cycle t, d_md=1 held → md_go=1 at t; md_busy=1 at t+1..t+5, 0 at t+6. d_we=0 for t..t+5 and 1 at t+6; stall_cnt=6.
- div with DIV_CYCLES=10 → md_busy high exactly 10 cycles. e_start_mul and e_start_div both set → 10-cycle load.
- req=1 together with e_start_div=1 → md_go=0, flush=1, pc_sel=1, pc_we=1, busy stays 0. req=1 during an existing BUSY → countdown continues unchanged.
- eret: d_eret=1, epc_wr_pending=1 → stall, pc_sel=0. Next cycle pending=0 → pc_sel=2, d_we=1.
- Drive reset=0 asynchronously mid-BUSY (cnt=3) → md_busy=0 and stall_cnt=0 before the next edge. flush=1 while reset is low.
